// File: rtl/multicycle_control_fsm.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Purpose:
//   Sequencing controller for the multi-cycle RISC-V core. Steps the shared
//   ALU, register file, PC and unified memory port through the
//   FETCH/DECODE/EXEC/MEM/WB phases. It also counts retired instructions and
//   keeps a sticky flag for illegal opcodes.
//
// Ports:
//   clk            - system clock, rising edge
//   rst_n          - asynchronous active-low reset
//   i_opcode       - instr[6:0] from the instruction register
//   i_funct3       - instr[14:12]
//   i_funct7_5     - instr[30]
//   i_mem_ready    - memory completes the current request this cycle
//   i_branch_taken - branch comparison result, meaningful in EXEC for BRANCH
//   o_mem_req      - memory request active
//   o_mem_we       - memory write (store)
//   o_ir_write     - load instruction register
//   o_pc_write     - PC <= PC+4
//   o_pc_branch    - PC <= branch target
//   o_alu_src_b    - 0 = rs2, 1 = immediate
//   o_alu_op       - ALU operation select
//   o_reg_write    - register file write enable
//   o_wb_sel       - 0 = ALU result, 1 = memory data
//   o_state        - current state (debug)
//   o_illegal      - sticky illegal-opcode flag
//   o_retired      - number of completed instructions (wraps silently)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic             i_funct7_5,
  input  logic             i_mem_ready,
  input  logic             i_branch_taken,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_pc_branch,
  output logic             o_alu_src_b,
  output logic [3:0]       o_alu_op,
  output logic             o_reg_write,
  output logic             o_wb_sel,
  output logic [2:0]       o_state,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_R      = 3'd0,
    CL_I      = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4
  } class_t;

  state_t             r_state;
  class_t             r_class;
  logic [2:0]         r_funct3;
  logic               r_funct7_5;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_retired;

  state_t             w_next_state;
  class_t             w_dec_class;
  logic               w_dec_legal;
  logic               w_retire;

  // Opcode classification. It is only consumed while in DECODE; the result is
  // latched there so later phases do not depend on the IR staying stable.
  always_comb begin
    w_dec_class = CL_R;
    w_dec_legal = 1'b1;
    case (i_opcode)
      7'b0110011: w_dec_class = CL_R;
      7'b0010011: w_dec_class = CL_I;
      7'b0000011: w_dec_class = CL_LOAD;
      7'b0100011: w_dec_class = CL_STORE;
      7'b1100011: w_dec_class = CL_BRANCH;
      default:    w_dec_legal = 1'b0;
    endcase
  end

  // State register, latched instruction fields, sticky illegal flag and the
  // retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_class    <= CL_R;
      r_funct3   <= 3'd0;
      r_funct7_5 <= 1'b0;
      r_illegal  <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE) begin
        if (w_dec_legal) begin
          r_class    <= w_dec_class;
          r_funct3   <= i_funct3;
          r_funct7_5 <= i_funct7_5;
        end else begin
          r_illegal <= 1'b1;
        end
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next-state and control decode. Every output defaults to 0 so IDLE, TRAP
  // and the unused encoding drive nothing into the datapath.
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_branch  = 1'b0;
    o_alu_src_b  = 1'b0;
    o_alu_op     = 4'b0000;
    o_reg_write  = 1'b0;
    o_wb_sel     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_write   = 1'b1;
          o_pc_write   = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next_state = w_dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        case (r_class)
          CL_R: begin
            o_alu_op     = {r_funct7_5, r_funct3};
            w_next_state = ST_WB;
          end
          CL_I: begin
            // Only the shift-right pair uses instr[30] to pick SRAI vs SRLI;
            // for the other immediates that bit is part of the immediate.
            o_alu_op     = {(r_funct3 == 3'b101) ? r_funct7_5 : 1'b0, r_funct3};
            o_alu_src_b  = 1'b1;
            w_next_state = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            o_alu_op     = 4'b0000;
            o_alu_src_b  = 1'b1;
            w_next_state = ST_MEM;
          end
          CL_BRANCH: begin
            o_alu_op     = 4'b1000;
            o_pc_branch  = i_branch_taken;
            w_retire     = 1'b1;
            w_next_state = ST_FETCH;
          end
          default: begin
            w_next_state = ST_TRAP;
          end
        endcase
      end
      ST_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = (r_class == CL_STORE);
        if (i_mem_ready) begin
          if (r_class == CL_STORE) begin
            w_retire     = 1'b1;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_WB;
          end
        end
      end
      ST_WB: begin
        o_reg_write  = 1'b1;
        o_wb_sel     = (r_class == CL_LOAD);
        w_retire     = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_TRAP: begin
        w_next_state = ST_TRAP;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign o_state   = r_state;
  assign o_illegal = r_illegal;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Purpose:
//   Self-checking bench for multicycle_control_fsm. Each instruction is
//   described at the phase level (class, wait counts, branch outcome). The
//   bench expands that description into the per-cycle state and control
//   values the controller must show. A narrow retired counter is used so the
//   wrap from all-ones to zero happens within the random run.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam int CW = 8;

  // Instruction classes used by the bench model
  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7_5;
  logic          memReady;
  logic          branchTaken;
  logic          memReq, memWe, irWrite, pcWrite, pcBranch, aluSrcB, regWrite, wbSel;
  logic [3:0]    aluOp;
  logic [2:0]    state;
  logic          illegal;
  logic [CW-1:0] retired;
  logic [11:0]   ctrlVec;

  int checks = 0;
  int errors = 0;
  int modelRetired = 0;
  logic modelIllegal = 1'b0;
  logic [6:0] classOpcode [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

  multicycle_control_fsm #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_opcode       (opcode),
    .i_funct3       (funct3),
    .i_funct7_5     (funct7_5),
    .i_mem_ready    (memReady),
    .i_branch_taken (branchTaken),
    .o_mem_req      (memReq),
    .o_mem_we       (memWe),
    .o_ir_write     (irWrite),
    .o_pc_write     (pcWrite),
    .o_pc_branch    (pcBranch),
    .o_alu_src_b    (aluSrcB),
    .o_alu_op       (aluOp),
    .o_reg_write    (regWrite),
    .o_wb_sel       (wbSel),
    .o_state        (state),
    .o_illegal      (illegal),
    .o_retired      (retired)
  );

  assign ctrlVec = {memReq, memWe, irWrite, pcWrite, pcBranch, aluSrcB, aluOp, regWrite, wbSel};

  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [11:0] mkCtrl(input logic mReq, input logic mWe, input logic irW,
                                         input logic pcW, input logic pcB, input logic srcB,
                                         input logic [3:0] op, input logic regW, input logic wb);
    return {mReq, mWe, irW, pcW, pcB, srcB, op, regW, wb};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input int expState, input logic [11:0] expCtrl);
    checkOutput($sformatf("state(exp %0d)", expState), 32'(state), 32'(expState));
    checkOutput($sformatf("ctrl@state%0d", expState), 32'(ctrlVec), 32'(expCtrl));
    checkOutput("illegal", 32'(illegal), 32'(modelIllegal));
    checkOutput("retired", 32'(retired), 32'(modelRetired % (1 << CW)));
  endtask

  // One clock cycle: drive inputs after the falling edge, check just after.
  task automatic applyStimulus(input int expState, input logic [11:0] expCtrl,
                               input logic mr, input logic bt, input logic [6:0] opc,
                               input logic [2:0] f3, input logic f7, input bit retireAfter);
    @(negedge clk);
    memReady    = mr;
    branchTaken = bt;
    opcode      = opc;
    funct3      = f3;
    funct7_5    = f7;
    #1;
    checkAll(expState, expCtrl);
    if (retireAfter) modelRetired++;
  endtask

  // Cycle whose non-relevant inputs are random noise
  task automatic noiseCycle(input int expState, input logic [11:0] expCtrl,
                            input logic mr, input bit useMr, input bit retireAfter);
    logic rmr;
    rmr = useMr ? mr : 1'($urandom_range(1));
    applyStimulus(expState, expCtrl, rmr, 1'($urandom_range(1)), 7'($urandom),
                  3'($urandom), 1'($urandom_range(1)), retireAfter);
  endtask

  // While rst_n is low: check reset state, then release and check IDLE
  task automatic resetAndIdle();
    @(negedge clk);
    #1;
    modelRetired = 0;
    modelIllegal = 1'b0;
    checkAll(0, 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll(0, 12'd0);
  endtask

  task automatic runFetch(input int fetchWait);
    for (int i = 0; i < fetchWait; i++)
      noiseCycle(1, mkCtrl(1, 0, 0, 0, 0, 0, 4'd0, 0, 0), 1'b0, 1'b1, 1'b0);
    noiseCycle(1, mkCtrl(1, 0, 1, 1, 0, 0, 4'd0, 0, 0), 1'b1, 1'b1, 1'b0);
  endtask

  // Full instruction from FETCH entry back to the next FETCH entry
  task automatic runInstr(input int cls, input logic [2:0] f3, input logic f7, input logic bt,
                          input int fetchWait, input int memWait);
    logic [3:0] op;
    logic       srcB;
    runFetch(fetchWait);
    applyStimulus(2, 12'd0, 1'($urandom_range(1)), 1'($urandom_range(1)), classOpcode[cls], f3, f7, 1'b0);
    case (cls)
      K_R:      op = 4'(f7) * 4'd8 + 4'(f3);
      K_I:      op = ((f3 == 3'd5 && f7) ? 4'd8 : 4'd0) + 4'(f3);
      K_BRANCH: op = 4'd8;
      default:  op = 4'd0;
    endcase
    srcB = (cls == K_I || cls == K_LOAD || cls == K_STORE);
    if (cls == K_BRANCH)
      applyStimulus(3, mkCtrl(0, 0, 0, 0, bt, 0, op, 0, 0), 1'($urandom_range(1)), bt,
                    7'($urandom), 3'($urandom), 1'($urandom_range(1)), 1'b1);
    else
      noiseCycle(3, mkCtrl(0, 0, 0, 0, 0, srcB, op, 0, 0), 1'b0, 1'b0, 1'b0);
    if (cls == K_LOAD || cls == K_STORE) begin
      for (int i = 0; i < memWait; i++)
        noiseCycle(4, mkCtrl(1, cls == K_STORE, 0, 0, 0, 0, 4'd0, 0, 0), 1'b0, 1'b1, 1'b0);
      noiseCycle(4, mkCtrl(1, cls == K_STORE, 0, 0, 0, 0, 4'd0, 0, 0), 1'b1, 1'b1, cls == K_STORE);
    end
    if (cls == K_R || cls == K_I || cls == K_LOAD)
      noiseCycle(5, mkCtrl(0, 0, 0, 0, 0, 0, 4'd0, 1, cls == K_LOAD), 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0; memReady = 1'b0; branchTaken = 1'b0;
    resetAndIdle();

    // Directed instructions, mem_ready high unless noted
    runInstr(K_R,      3'b000, 1'b0, 1'b0, 0, 0);
    runInstr(K_I,      3'b101, 1'b1, 1'b0, 0, 0);
    runInstr(K_LOAD,   3'b010, 1'b0, 1'b0, 0, 3);
    runInstr(K_STORE,  3'b010, 1'b0, 1'b0, 0, 0);
    runInstr(K_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0);
    runInstr(K_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0);
    runInstr(K_I,      3'b101, 1'b0, 1'b0, 2, 0);
    runInstr(K_R,      3'b000, 1'b1, 1'b0, 0, 0);

    // Random run, long enough to wrap the retired counter
    for (int n = 0; n < 320; n++)
      runInstr($urandom_range(4), 3'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
               $urandom_range(2), $urandom_range(3));
    checkOutput("retiredWrapped", 32'(modelRetired > (1 << CW)), 32'd1);

    // Reset in the middle of a stalled load: outputs must drop without a clock edge
    runFetch(0);
    applyStimulus(2, 12'd0, 1'b1, 1'b0, classOpcode[K_LOAD], 3'b010, 1'b0, 1'b0);
    noiseCycle(3, mkCtrl(0, 0, 0, 0, 0, 1, 4'd0, 0, 0), 1'b0, 1'b0, 1'b0);
    noiseCycle(4, mkCtrl(1, 0, 0, 0, 0, 0, 4'd0, 0, 0), 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("memReqAsyncDrop", 32'(memReq), 32'd0);
    checkOutput("stateAsyncReset", 32'(state), 32'd0);
    resetAndIdle();

    // Illegal opcode: TRAP is absorbing until reset
    runInstr(K_STORE, 3'b000, 1'b0, 1'b0, 0, 0);
    runFetch(0);
    applyStimulus(2, 12'd0, 1'b1, 1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0);
    modelIllegal = 1'b1;
    for (int i = 0; i < 20; i++)
      noiseCycle(6, 12'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("illegalClearedByReset", 32'(illegal), 32'd0);
    checkOutput("trapExitState", 32'(state), 32'd0);
    resetAndIdle();
    runInstr(K_R, 3'b111, 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle RISC-V core: steps shared ALU, register file, PC and unified memory port through FETCH/DECODE/EXEC/MEM/WB.
- Replaces per-instruction combinational control with a registered state machine plus a retired-instruction counter.
- Sits between the instruction register / memory interface and the datapath muxes.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- mem_ready  in  1  memory completes current request this cycle
- branch_taken  in  1  datapath branch comparison result, valid in EXEC
- mem_req  out  1  memory request active
- mem_we  out  1  memory write (store)
- ir_write  out  1  load instruction register
- pc_write  out  1  PC <= PC+4
- pc_branch  out  1  PC <= branch target
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  4  ALU operation select
- reg_write  out  1  register file write enable
- wb_sel  out  1  0 = ALU result, 1 = memory data
- state  out  3  current state (debug)
- illegal  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  instructions completed

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. State, latched class, illegal and retired are registers; rst_n low asynchronously forces IDLE, illegal=0, retired=0.
- All control outputs are combinational from state, latched class/fields, mem_ready and branch_taken. All are 0 in IDLE and TRAP, so every output is 0 during and immediately after reset.
- IDLE -> FETCH unconditionally, one cycle after rst_n deasserts.
- FETCH:
  - mem_req=1, mem_we=0; hold while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, next DECODE.
- DECODE:
  - Classify opcode and latch class, funct3 and funct7_5: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH.
  - Any other opcode -> TRAP with illegal set.
- EXEC, alu_op by class:
  - R: {funct7_5, funct3}.
  - I: {funct3==3'b101 ? funct7_5 : 0, funct3}.
  - LOAD/STORE: 4'b0000 (add).
  - BRANCH: 4'b1000 (sub).
- EXEC, alu_src_b: 1 for I/LOAD/STORE, else 0.
- EXEC, next state:
  - R/I -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH -> FETCH, with pc_branch=branch_taken in the same cycle and retired incremented.
- MEM:
  - mem_req=1, mem_we=1 for STORE only; hold while mem_ready=0.
  - On mem_ready: STORE -> FETCH with retired incremented; LOAD -> WB.
- WB: reg_write=1, wb_sel=1 for LOAD else 0; next FETCH, retired incremented.
- TRAP: absorbing; all controls 0 and illegal held at 1 until reset.
- Minimum latencies (mem_ready tied high), FETCH entry to next FETCH entry: BRANCH 3, R/I 4, STORE 4, LOAD 5 cycles.
- retired wraps from all-ones to 0 with no flag.
- pc_write and pc_branch are never asserted in the same cycle.
- Reset mid-transaction (e.g. during MEM with mem_req high): outputs drop to 0 asynchronously; the pending memory access is abandoned.
- mem_ready outside FETCH/MEM is ignored. branch_taken outside EXEC/BRANCH is ignored.

Test Plan:
- Reset release, mem_ready=1, R-type add (0110011, funct3=000, funct7_5=0): state sequence 0,1,2,3,5,1. alu_op=0000 in EXEC, reg_write=1 only in WB, retired=1.
- I-type srai (0010011, funct3=101, funct7_5=1): alu_op=1101, alu_src_b=1 in EXEC.
- LOAD with mem_ready low for 3 MEM cycles: MEM held 4 cycles with mem_req=1, mem_we=0; then WB with wb_sel=1; retired +1.
- STORE: MEM asserts mem_we=1, reg_write never asserted, returns to FETCH. BRANCH with branch_taken=1: pc_branch=1 in EXEC, 3 cycles total. BRANCH with branch_taken=0: pc_branch=0.
- Opcode 1111111: TRAP entered after DECODE, illegal=1, all controls 0 for 20 cycles; rst_n pulse clears illegal and state returns to IDLE.
- Preload retired to all-ones via forced state, retire one instruction: retired=0. Assert rst_n low mid-MEM: mem_req falls without waiting for a clock edge.
